// File: rtl/mux_array_pipe.sv
// -----------------------------------------------------------------------------
// mux_array_pipe
//
// Registered, handshaked N-channel selector for the CompactRISC16 operand path.
// Each accepted transfer picks one WIDTH-bit word out of CHANNELS input words,
// either by the external select or by an internal round-robin scan pointer.
// The word is presented with the index of the channel that produced it through
// a one-stage valid/ready output register.
//
// Parameters
//   WIDTH     bits per channel word
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     select/tag width, derived from CHANNELS (do not override)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   mode       0 = external select, 1 = round-robin scan
//   sel        channel select used when mode = 0
//   in_data    channel k at [k*WIDTH +: WIDTH]
//   in_valid   source offers a transfer
//   in_ready   block accepts a transfer this cycle
//   out_data   selected word
//   out_chan   channel index that produced out_data
//   out_valid  out_data/out_chan are valid
//   out_ready  sink accepts the output this cycle
//
// Build option
//   MUX_ARRAY_PIPE_SKID_EN  adds a one-entry skid register so that in_ready
//                           comes straight from a flop and has no
//                           combinational path from out_ready.
// -----------------------------------------------------------------------------
module mux_array_pipe #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   // A selected word travels together with the channel that produced it.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] chan;
   } word_t;

   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] eff_chan;
   word_t            new_word;
   word_t            out_q;
   logic             accept;
   logic             out_free;

   // Channel select and data mux. An effective channel that names no
   // physical channel (non-power-of-2 CHANNELS) yields a zero word but
   // still reports the requested index as its tag.
   // NOTE: every variable written here gets a default first, so no path
   // through the loop can leave a value unassigned and infer a latch.
   always_comb begin
      eff_chan      = mode ? ptr : sel;
      new_word.data = '0;
      new_word.chan = eff_chan;
      for (int k = 0; k < CHANNELS; k++) begin
         if (eff_chan == SEL_W'(k)) begin
            new_word.data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // The output register may take a new word whenever it is empty or its
   // current word leaves this cycle.
   assign out_free = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Round-robin scan pointer: advances only on accepts made in scan mode
   // and survives mode changes, so a scan resumes where it left off.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (accept && mode) begin
         ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end
   end

`ifdef MUX_ARRAY_PIPE_SKID_EN

   // Skid build: a word accepted while the output is stalled parks in the
   // skid register. in_ready is the inverse of the skid-full flop, so it
   // only drops the cycle after the skid fills.
   word_t skid_q;
   logic  skid_full;

   assign in_ready = ~skid_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= '0;
         out_valid <= 1'b0;
         skid_q    <= '0;
         skid_full <= 1'b0;
      end else if (out_free) begin
         // The skid entry is older than anything arriving now, and no
         // accept can happen while it is full, so it always goes first.
         if (skid_full) begin
            out_q     <= skid_q;
            out_valid <= 1'b1;
            skid_full <= 1'b0;
         end else begin
            if (accept) begin
               out_q <= new_word;
            end
            out_valid <= accept;
         end
      end else if (accept) begin
         skid_q    <= new_word;
         skid_full <= 1'b1;
      end
   end

`else

   // Base build: a word can enter only when the output register is free,
   // which gives one word per cycle under continuous flow.
   assign in_ready = out_free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out_q     <= new_word;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`endif

   assign out_data = out_q.data;
   assign out_chan = out_q.chan;

endmodule

// File: tb/tb_mux_array_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_array_pipe
//
// Directed and randomized checks for mux_array_pipe (4-channel instance) plus a
// 3-channel instance for the out-of-range select and short-wrap cases.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// either 1 unit after the edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_mux_array_pipe;

   localparam int W = 16;

`ifdef MUX_ARRAY_PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] d;
      logic [1:0]   c;
   } exp_t;

   logic          clk;
   logic          reset_n;

   // 4-channel DUT
   logic          mode;
   logic [1:0]    sel;
   logic [4*W-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    out_chan;
   logic          out_valid;
   logic          out_ready;

   // 3-channel DUT
   logic          mode3;
   logic [1:0]    sel3;
   logic [3*W-1:0] in_data3;
   logic          in_valid3;
   logic          in_ready3;
   logic [W-1:0]  out_data3;
   logic [1:0]    out_chan3;
   logic          out_valid3;
   logic          out_ready3;

   int checks = 0;
   int errors = 0;

   // scoreboard state
   bit   sb_en = 1'b0;
   exp_t exp_q[$];
   int   mptr = 0;
   int   acc_cnt = 0;
   int   xfer_cnt = 0;

   mux_array_pipe #(.WIDTH(W), .CHANNELS(4)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode),
      .sel      (sel),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_chan (out_chan),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   mux_array_pipe #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode3),
      .sel      (sel3),
      .in_data  (in_data3),
      .in_valid (in_valid3),
      .in_ready (in_ready3),
      .out_data (out_data3),
      .out_chan (out_chan3),
      .out_valid(out_valid3),
      .out_ready(out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      #2;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   // Scoreboard: handshakes sampled on the falling edge complete on the next
   // rising edge. The outgoing word is retired before the incoming one is
   // queued, since in a simultaneous transfer the output holds the older word.
   always @(negedge clk) begin
      if (sb_en) begin
         if (out_valid && out_ready) begin
            xfer_cnt++;
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_data", out_data, e.d);
               check("sb_chan", out_chan, e.c);
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            int   eff;
            acc_cnt++;
            eff = mode ? mptr : int'(sel);
            e.d = in_data[eff*W +: W];
            e.c = 2'(eff);
            exp_q.push_back(e);
            if (mode) mptr = (mptr == 3) ? 0 : mptr + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n_acc;
      int a0, x0;
      logic [W-1:0] bp_word [0:2];

      reset_n   = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mode3     = 1'b0;
      sel3      = '0;
      in_data3  = '0;
      in_valid3 = 1'b0;
      out_ready3 = 1'b0;

      // ---------------- reset state ----------------
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_out_chan",  out_chan,  0);
      check("rst_in_ready",  in_ready,  1);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // ---------------- mode 0, sel = 2 ----------------
      in_data   = 64'h4444_3333_2222_1111;
      sel       = 2'd2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("m0_out_valid", out_valid, 1);
      check("m0_out_data",  out_data,  16'h3333);
      check("m0_out_chan",  out_chan,  2);
      tick();
      check("m0_drained", out_valid, 0);

      // ---------------- round-robin ----------------
      in_data  = 64'hA003_A002_A001_A000;
      mode     = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_chan",  out_chan,  i % 4);
         check("rr_data",  out_data,  16'hA000 + 16'(i % 4));
         check("rr_valid", out_valid, 1);
      end
      // pointer must now be 2: an external-select accept must not move it
      mode = 1'b0;
      sel  = 2'd3;
      tick();
      check("rr_m0_chan", out_chan, 3);
      check("rr_m0_data", out_data, 16'hA003);
      mode = 1'b1;
      tick();
      check("rr_resume_chan", out_chan, 2);
      check("rr_resume_data", out_data, 16'hA002);
      in_valid = 1'b0;
      mode     = 1'b0;
      tick();
      check("rr_drained", out_valid, 0);

      // ---------------- backpressure ----------------
      sel       = 2'd0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      n_acc     = 0;
      in_data   = {48'h0, 16'hB000};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         // base: only the first cycle (empty output) accepts; skid: first two
         check("bp_in_ready", in_ready, (c == 0) || (SKID && c == 1));
         if (in_ready) begin
            bp_word[n_acc] = in_data[W-1:0];
            n_acc++;
         end
         tick();
         in_data = {48'h0, 16'hB000 + 16'(n_acc)};
         check("bp_hold_data", out_data, 16'hB000);
         check("bp_hold_valid", out_valid, 1);
      end
      check("bp_accepts", n_acc, SKID ? 2 : 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < n_acc; k++) begin
         @(negedge clk);
         check("bp_drain_valid", out_valid, 1);
         check("bp_drain_data",  out_data,  bp_word[k]);
         tick();
      end
      check("bp_empty", out_valid, 0);

      // ---------------- reset mid-stall ----------------
      in_data   = {48'h0, 16'hC0DE};
      sel       = 2'd0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      check("ms_pre_valid", out_valid, 1);
      check("ms_pre_data",  out_data,  16'hC0DE);
      check("ms_pre_ready", in_ready,  0);
      #2;
      reset_n = 1'b0;
      #1;
      check("ms_async_valid", out_valid, 0);
      check("ms_async_data",  out_data,  0);
      check("ms_async_chan",  out_chan,  0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("ms_rel_ready", in_ready,  1);
      check("ms_rel_valid", out_valid, 0);

      // ---------------- 3-channel instance ----------------
      in_data3   = 48'hCCCC_BBBB_AAAA;
      sel3       = 2'd3;
      mode3      = 1'b0;
      in_valid3  = 1'b1;
      out_ready3 = 1'b1;
      tick();
      check("oor_data",  out_data3,  0);
      check("oor_chan",  out_chan3,  3);
      check("oor_valid", out_valid3, 1);
      sel3 = 2'd2;
      tick();
      check("c3_sel2_data", out_data3, 16'hCCCC);
      mode3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("c3_rr_chan", out_chan3, i % 3);
         check("c3_rr_data", out_data3, (i % 3 == 0) ? 16'hAAAA :
                                         (i % 3 == 1) ? 16'hBBBB : 16'hCCCC);
      end
      in_valid3 = 1'b0;
      tick();
      check("c3_drained", out_valid3, 0);

      // ---------------- random traffic with scoreboard ----------------
      reset_pulse();
      mptr  = 0;
      sb_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         in_data   = {$urandom, $urandom};
         sel       = 2'($urandom_range(0, 3));
         mode      = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("rnd_queue_empty", exp_q.size(), 0);

      // continuous flow: one accept per cycle, outputs follow one cycle later
      a0 = acc_cnt;
      x0 = xfer_cnt;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         in_data = {$urandom, $urandom};
         sel     = 2'($urandom_range(0, 3));
         mode    = 1'($urandom_range(0, 1));
         tick();
      end
      check("tput_accepts", acc_cnt - a0, 50);
      check("tput_xfers",   xfer_cnt - x0, 49);
      in_valid = 1'b0;
      repeat (3) tick();
      check("tput_queue_empty", exp_q.size(), 0);
      sb_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
